// File: rtl/afifo_wr_ctrl.sv
// afifo_wr_ctrl: write-domain pointer controller for a dual-clock FIFO
// Gray write pointer export, 2-flop read-pointer synchroniser, full/afull/fill status
module afifo_wr_ctrl #(
    parameter int PTR_WIDTH    = 4,
    parameter int AFULL_THRESH = 12
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wr_req,
    input  logic [PTR_WIDTH:0]   rd_ptr_gry_async,
    output logic                 wr_en,
    output logic [PTR_WIDTH-1:0] wr_addr,
    output logic [PTR_WIDTH:0]   wr_ptr_gry,
    output logic                 full,
    output logic                 afull,
    output logic [PTR_WIDTH:0]   fill_lvl,
    output logic                 ovrflw
);
    localparam logic [PTR_WIDTH:0] THRESH = (PTR_WIDTH+1)'(AFULL_THRESH);
    logic [PTR_WIDTH:0] wr_bin_f, wr_bin_nxt, wr_gry_nxt, rd_sync, rd_gry_s, rd_bin_s, lvl_nxt;
    assign wr_en      = wr_req & ~full;
    assign wr_addr    = wr_bin_f[PTR_WIDTH-1:0];
    assign wr_bin_nxt = wr_bin_f + (PTR_WIDTH+1)'(wr_en);
    assign wr_gry_nxt = wr_bin_nxt ^ (wr_bin_nxt >> 1);
    assign lvl_nxt    = wr_bin_nxt - rd_bin_s;
    for (genvar i = 0; i <= PTR_WIDTH; i++) begin : g_bin
        assign rd_bin_s[i] = ^rd_gry_s[PTR_WIDTH:i];
    end
    // status uses the synchronised (possibly stale) read pointer, so it can only overstate fill
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_sync    <= '0;
            rd_gry_s   <= '0;
            wr_bin_f   <= '0;
            wr_ptr_gry <= '0;
            full       <= 1'b0;
            afull      <= 1'b0;
            fill_lvl   <= '0;
            ovrflw     <= 1'b0;
        end else begin
            rd_sync    <= rd_ptr_gry_async;
            rd_gry_s   <= rd_sync;
            wr_bin_f   <= wr_bin_nxt;
            wr_ptr_gry <= wr_gry_nxt;
            full       <= wr_gry_nxt == {~rd_gry_s[PTR_WIDTH:PTR_WIDTH-1], rd_gry_s[PTR_WIDTH-2:0]};
            afull      <= lvl_nxt >= THRESH;
            fill_lvl   <= lvl_nxt;
            ovrflw     <= wr_req & full;
        end
    end
endmodule

// File: tb/tb_afifo_wr_ctrl.sv
// tb_afifo_wr_ctrl: scoreboard bench; a count-based reference model predicts every cycle's outputs
module tb_afifo_wr_ctrl;
    localparam int PW    = 4;
    localparam int DEPTH = 1 << PW;
    localparam int TH    = 12;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          wr_req;
    logic [PW:0]   rd_ptr_gry_async;
    logic          wr_en;
    logic [PW-1:0] wr_addr;
    logic [PW:0]   wr_ptr_gry;
    logic          full;
    logic          afull;
    logic [PW:0]   fill_lvl;
    logic          ovrflw;

    afifo_wr_ctrl #(.PTR_WIDTH(PW), .AFULL_THRESH(TH)) dut (
        .clk(clk), .rst_n(rst_n), .wr_req(wr_req), .rd_ptr_gry_async(rd_ptr_gry_async),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_ptr_gry(wr_ptr_gry), .full(full),
        .afull(afull), .fill_lvl(fill_lvl), .ovrflw(ovrflw)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          en;
        logic [PW-1:0] addr;
        logic [PW:0]   gry;
        logic          full;
        logic          afull;
        logic [PW:0]   lvl;
        logic          ovr;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // reference model: plain counts of accepted writes and of reads issued
    int   wc, rd_cnt, fill_m;
    bit   full_m, afull_m, ovr_m;
    int   rdq[$];

    function automatic logic [PW:0] gray(input int v);
        logic [PW:0] b;
        b = (PW+1)'(v);
        return b ^ (b >> 1);
    endfunction

    task automatic check(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s got %0h want %0h at %0t", n, a, e, $time);
        end
    endtask

    task automatic model_reset();
        wc = 0; rd_cnt = 0; fill_m = 0;
        full_m = 0; afull_m = 0; ovr_m = 0;
        rdq = '{0, 0};
    endtask

    // the write side sees the read count that was driven two edges earlier
    task automatic model_edge();
        int rvis;
        bit en;
        if (!rst_n) return;
        en    = wr_req && !full_m;
        ovr_m = wr_req && full_m;
        wc    = wc + int'(en);
        rvis  = rdq.pop_front();
        rdq.push_back(rd_cnt);
        fill_m  = wc - rvis;
        full_m  = fill_m >= DEPTH;
        afull_m = fill_m >= TH;
    endtask

    task automatic push_exp();
        exp_t e;
        e.en    = wr_req && !full_m;
        e.addr  = PW'(wc);
        e.gry   = gray(wc);
        e.full  = full_m;
        e.afull = afull_m;
        e.lvl   = (PW+1)'(fill_m);
        e.ovr   = ovr_m;
        exp_q.push_back(e);
    endtask

    task automatic cycle(input bit req, input bit rinc);
        @(posedge clk);
        model_edge();
        #2;
        wr_req = req;
        if (rinc && rd_cnt < wc) rd_cnt++;
        rd_ptr_gry_async = gray(rd_cnt);
        push_exp();
    endtask

    task automatic do_reset();
        @(posedge clk);
        model_edge();
        #2;
        rst_n = 1'b0;
        wr_req = 1'b0;
        rd_ptr_gry_async = '0;
        model_reset();
        push_exp();
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        push_exp();
    endtask

    // monitor: every cycle's outputs are compared against the queued prediction
    logic [PW:0] prev_gry = '0;
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("wr_en",      32'(wr_en),      32'(e.en));
            check("wr_addr",    32'(wr_addr),    32'(e.addr));
            check("wr_ptr_gry", 32'(wr_ptr_gry), 32'(e.gry));
            check("full",       32'(full),       32'(e.full));
            check("afull",      32'(afull),      32'(e.afull));
            check("fill_lvl",   32'(fill_lvl),   32'(e.lvl));
            check("ovrflw",     32'(ovrflw),     32'(e.ovr));
        end
        if (!rst_n) prev_gry = '0;
        else if (wr_ptr_gry != prev_gry) begin
            check("gry_step", 32'($countones(wr_ptr_gry ^ prev_gry)), 32'd1);
            prev_gry = wr_ptr_gry;
        end
    end

    initial begin
        rst_n = 1'b0;
        wr_req = 1'b0;
        rd_ptr_gry_async = '0;
        model_reset();
        @(posedge clk);
        #2;
        push_exp();
        rst_n = 1'b1;
        repeat (20) cycle(1'b1, 1'b0);
        cycle(1'b0, 1'b1);
        repeat (3) cycle(1'b0, 1'b0);
        repeat (3) cycle(1'b1, 1'b0);
        repeat (20) cycle(1'b0, 1'b1);
        repeat (45) cycle(1'b1, (wc - rd_cnt) > 2);
        for (int p = 0; p < 8; p++)
            repeat (400) cycle($urandom_range(0, 3) != 0, $urandom_range(0, 7) < p + 1);
        repeat (10) cycle(1'b1, 1'b0);
        do_reset();
        repeat (5) cycle(1'b1, 1'b0);
        repeat (300) cycle($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0);
        @(negedge clk);
        #1;
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
